pe_feeder: RTL and testbench
============================

PE_FEEDER -- requirements
Module: pe_feeder

Interface
REQ-001 The block SHALL have parameter DEPTH, default 9, giving the number of tap buffer entries (legal range 1..15).
REQ-002 The block SHALL have parameter AW, default 4, giving the tap address and tap count width.
REQ-003 clk  input  1  clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 wr_en  input  1  tap buffer write strobe.
REQ-006 wr_sel  input  1  write target select: 0 = input buffer, 1 = filter buffer.
REQ-007 wr_addr  input  AW  tap buffer write address.
REQ-008 wr_data  input  8  tap buffer write data.
REQ-009 start  input  1  single-cycle request to begin one dot product.
REQ-010 tap_cnt  input  AW  number of taps for the run; sampled when start is accepted.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 pe_in  output  8  input operand driven to the PE.
REQ-013 pe_filter  output  8  filter operand driven to the PE.
REQ-014 mode_out  output  2  PE mode: 0 = reset, 1 = accumulate.
REQ-015 pe_result  input  8  PE result (pe_out), sampled by this block.
REQ-016 res_valid  output  1  result available.
REQ-017 res_data  output  8  captured result.
REQ-018 res_ready  input  1  downstream accepts the result.

Function
REQ-019 Tap buffers SHALL be two DEPTH x 8 register arrays; a write SHALL occur on a clock edge only when wr_en=1, busy=0 and wr_addr<DEPTH, and SHALL otherwise be dropped.
REQ-020 The FSM SHALL have four states: IDLE, RUN, CAPT, OUT.
REQ-021 IDLE->RUN SHALL occur when start=1 and tap_cnt!=0; start SHALL be ignored when tap_cnt=0 or busy=1.
REQ-022 The latched run length SHALL be min(tap_cnt, DEPTH).
REQ-023 In RUN, index k SHALL advance 0..N-1, one tap per cycle; pe_in and pe_filter SHALL be registered buffer entry k and mode_out SHALL be 1 in each of those N cycles.
REQ-024 The first accumulate cycle SHALL be the cycle immediately after the start-accept edge.
REQ-025 RUN->CAPT SHALL occur after the N-th RUN cycle.
REQ-026 In CAPT, mode_out SHALL be 0, pe_in and pe_filter SHALL be 0, and pe_result SHALL be registered into res_data at the end of the cycle.
REQ-027 CAPT->OUT SHALL be unconditional.
REQ-028 In OUT, res_valid SHALL be 1 and res_data SHALL be held stable until res_ready=1.
REQ-029 OUT->IDLE SHALL occur on the edge where res_ready=1; res_ready SHALL be ignored outside OUT.
REQ-030 Outside RUN, mode_out, pe_in and pe_filter SHALL be 0.
REQ-031 Total latency from start accept to res_valid SHALL be N+2 cycles.
REQ-032 A start asserted in the same cycle as the OUT->IDLE handshake SHALL be ignored.

Reset
REQ-033 rst=1 SHALL force IDLE asynchronously, including mid-run.
REQ-034 On reset, k and the latched N SHALL be 0, busy, res_valid and mode_out SHALL be 0, and pe_in, pe_filter and res_data SHALL be 8'h00.
REQ-035 Tap buffer contents SHALL be cleared to 0 on reset.

Configuration
REQ-036 Macro PE_FEEDER_RELU_EN SHALL control a ReLU stage in the CAPT path.
REQ-037 With PE_FEEDER_RELU_EN defined, the CAPT stage SHALL register 8'h00 when pe_result[7]=1 and pe_result otherwise.
REQ-038 Without PE_FEEDER_RELU_EN, pe_result SHALL be registered unchanged.

Verification
REQ-039 Load in={1,2,3}, filt={4,5,6}, start with tap_cnt=3 -> pe_in/pe_filter show (1,4),(2,5),(3,6) with mode_out=1 on cycles 1-3; res_valid on cycle 5; res_data equals pe_result sampled in CAPT (32 with a PE model).
REQ-040 Hold res_ready=0 for 4 cycles in OUT -> res_valid stays 1 and res_data stays stable; raising res_ready returns the FSM to IDLE on the next edge with busy=0.
REQ-041 Issue start with tap_cnt=0, then tap_cnt=12 (DEPTH=9) -> the first start is ignored (busy stays 0); the second gives exactly 9 mode_out=1 cycles.
REQ-042 Issue a write to wr_addr=2 with busy=1, and a write to wr_addr=10 -> both are dropped, and a readback run shows the old values.
REQ-043 Assert rst during the 2nd RUN cycle -> busy, mode_out, pe_in and res_valid are 0 immediately; a new start after reset runs cleanly with zeroed buffers.
REQ-044 With PE_FEEDER_RELU_EN defined, pe_result=8'hF0 in CAPT -> res_data=8'h00; pe_result=8'h35 -> res_data=8'h35; without the macro, 8'hF0 passes through unchanged.

Source files
------------

// File: rtl/pe_feeder.sv
`default_nettype none
// ============================================================================
// Module   : pe_feeder
// Purpose  : Streams two tap buffers into a PE for one dot product, then
//            captures and hands off the PE result with a valid/ready handshake.
//            Optional ReLU on the captured result: define PE_FEEDER_RELU_EN.
// Revision : 1.0
// ============================================================================
module pe_feeder #(
    parameter int DEPTH = 9,
    parameter int AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr_en_i,
    input  logic          wr_sel_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic          start_i,
    input  logic [AW-1:0] tap_cnt_i,
    output logic          busy_o,
    output logic [7:0]    pe_in_o,
    output logic [7:0]    pe_filter_o,
    output logic [1:0]    mode_out_o,
    input  logic [7:0]    pe_result_i,
    output logic          res_valid_o,
    output logic [7:0]    res_data_o,
    input  logic          res_ready_i
);

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_capt = 2'd2;
    localparam logic [1:0] c_out  = 2'd3;

    localparam logic [AW-1:0] c_depth = AW'(DEPTH);
    localparam logic [1:0]    c_mode_rst = 2'd0;
    localparam logic [1:0]    c_mode_acc = 2'd1;

    logic [7:0]    in_buf_q   [DEPTH];
    logic [7:0]    filt_buf_q [DEPTH];

    logic [1:0]    state_q,     state_d;
    logic [AW-1:0] k_q,         k_d;
    logic [AW-1:0] n_q,         n_d;
    logic [7:0]    pe_in_q,     pe_in_d;
    logic [7:0]    pe_filter_q, pe_filter_d;
    logic [1:0]    mode_q,      mode_d;
    logic [7:0]    res_data_q,  res_data_d;

    logic          w_wr_ok;
    logic [AW-1:0] w_rd_idx;
    logic [7:0]    w_rd_in;
    logic [7:0]    w_rd_filt;
    logic [7:0]    w_capt_val;
    logic [AW-1:0] w_run_len;

    assign busy_o      = (state_q != c_idle);
    assign res_valid_o = (state_q == c_out);
    assign pe_in_o     = pe_in_q;
    assign pe_filter_o = pe_filter_q;
    assign mode_out_o  = mode_q;
    assign res_data_o  = res_data_q;

    // Out-of-range addresses match no entry in the decode loop and are dropped.
    assign w_wr_ok = wr_en_i && !busy_o;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                in_buf_q[i]   <= 8'h00;
                filt_buf_q[i] <= 8'h00;
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (w_wr_ok && (wr_addr_i == AW'(i))) begin
                    if (wr_sel_i) begin
                        filt_buf_q[i] <= wr_data_i;
                    end else begin
                        in_buf_q[i]   <= wr_data_i;
                    end
                end
            end
        end
    end

    // Operands are fetched one entry ahead so they are registered in the tap cycle.
    assign w_rd_idx = (state_q == c_run) ? (k_q + AW'(1)) : '0;

    always_comb begin
        w_rd_in   = 8'h00;
        w_rd_filt = 8'h00;
        for (int i = 0; i < DEPTH; i++) begin
            if (w_rd_idx == AW'(i)) begin
                w_rd_in   = in_buf_q[i];
                w_rd_filt = filt_buf_q[i];
            end
        end
    end

    assign w_run_len = (tap_cnt_i > c_depth) ? c_depth : tap_cnt_i;

`ifdef PE_FEEDER_RELU_EN
    assign w_capt_val = pe_result_i[7] ? 8'h00 : pe_result_i;
`else
    assign w_capt_val = pe_result_i;
`endif

    always_comb begin
        state_d     = state_q;
        k_d         = k_q;
        n_d         = n_q;
        pe_in_d     = 8'h00;
        pe_filter_d = 8'h00;
        mode_d      = c_mode_rst;
        res_data_d  = res_data_q;
        case (state_q)
            c_idle: begin
                if (start_i && (tap_cnt_i != '0)) begin
                    state_d     = c_run;
                    k_d         = '0;
                    n_d         = w_run_len;
                    pe_in_d     = w_rd_in;
                    pe_filter_d = w_rd_filt;
                    mode_d      = c_mode_acc;
                end
            end
            c_run: begin
                if (k_q == (n_q - AW'(1))) begin
                    state_d = c_capt;
                    k_d     = '0;
                end else begin
                    k_d         = k_q + AW'(1);
                    pe_in_d     = w_rd_in;
                    pe_filter_d = w_rd_filt;
                    mode_d      = c_mode_acc;
                end
            end
            c_capt: begin
                res_data_d = w_capt_val;
                state_d    = c_out;
            end
            c_out: begin
                if (res_ready_i) begin
                    state_d = c_idle;
                end
            end
            default: begin
                state_d = c_idle;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= c_idle;
            k_q         <= '0;
            n_q         <= '0;
            pe_in_q     <= 8'h00;
            pe_filter_q <= 8'h00;
            mode_q      <= c_mode_rst;
            res_data_q  <= 8'h00;
        end else begin
            state_q     <= state_d;
            k_q         <= k_d;
            n_q         <= n_d;
            pe_in_q     <= pe_in_d;
            pe_filter_q <= pe_filter_d;
            mode_q      <= mode_d;
            res_data_q  <= res_data_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_feeder.sv
`default_nettype none
// ============================================================================
// Module   : tb_pe_feeder
// Purpose  : Self-checking bench for pe_feeder with an accumulating PE model.
// Revision : 1.0
// ============================================================================
module tb_pe_feeder;

    localparam int DEPTH = 9;
    localparam int AW    = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic          wr_sel = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic          start = 1'b0;
    logic [AW-1:0] tap_cnt = '0;
    logic          busy;
    logic [7:0]    pe_in;
    logic [7:0]    pe_filter;
    logic [1:0]    mode_out;
    logic [7:0]    pe_result;
    logic          res_valid;
    logic [7:0]    res_data;
    logic          res_ready = 1'b0;

    logic [7:0]    acc;
    logic          ovr_en = 1'b0;
    logic [7:0]    ovr_val = 8'h00;

    logic [7:0]    m_in   [DEPTH];
    logic [7:0]    m_filt [DEPTH];

    int errors = 0;
    int checks = 0;

    pe_feeder #(.DEPTH(DEPTH), .AW(AW)) dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en_i     (wr_en),
        .wr_sel_i    (wr_sel),
        .wr_addr_i   (wr_addr),
        .wr_data_i   (wr_data),
        .start_i     (start),
        .tap_cnt_i   (tap_cnt),
        .busy_o      (busy),
        .pe_in_o     (pe_in),
        .pe_filter_o (pe_filter),
        .mode_out_o  (mode_out),
        .pe_result_i (pe_result),
        .res_valid_o (res_valid),
        .res_data_o  (res_data),
        .res_ready_i (res_ready)
    );

    always #5 clk = ~clk;

    // PE: accumulates in*filter while mode=1, clears otherwise.
    always @(posedge clk or posedge rst) begin
        if (rst)                acc <= 8'h00;
        else if (mode_out == 2'd1) acc <= acc + 8'(pe_in * pe_filter);
        else                    acc <= 8'h00;
    end
    assign pe_result = ovr_en ? ovr_val : acc;

    function automatic logic [7:0] relu_ref(input logic [7:0] v);
`ifdef PE_FEEDER_RELU_EN
        return v[7] ? 8'h00 : v;
`else
        return v;
`endif
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        for (int i = 0; i < DEPTH; i++) begin
            m_in[i]   = 8'h00;
            m_filt[i] = 8'h00;
        end
    endtask

    task automatic do_write(input logic sel, input int addr, input logic [7:0] data);
        wr_en   = 1'b1;
        wr_sel  = sel;
        wr_addr = AW'(addr);
        wr_data = data;
        step();
        wr_en   = 1'b0;
        if (addr < DEPTH) begin
            if (sel) m_filt[addr] = data;
            else     m_in[addr]   = data;
        end
    endtask

    // One full run: start accept, N tap cycles, CAPT, OUT with optional hold.
    task automatic run_check(input int tap, input bit wr_busy, input bit use_ovr,
                             input logic [7:0] ovr, input int hold);
        int n;
        int s;
        logic [7:0] exp_res;
        logic [19:0] act;
        logic [19:0] exp_v;
        n = (tap > DEPTH) ? DEPTH : tap;
        s = 0;
        for (int k = 0; k < n; k++) s += int'(m_in[k]) * int'(m_filt[k]);
        exp_res = use_ovr ? relu_ref(ovr) : relu_ref(s[7:0]);

        start   = 1'b1;
        tap_cnt = AW'(tap);
        step();
        start   = 1'b0;
        for (int k = 0; k < n; k++) begin
            act   = {busy, mode_out, pe_in, pe_filter, res_valid};
            exp_v = {1'b1, 2'd1, m_in[k], m_filt[k], 1'b0};
            checks++;
            if (act !== exp_v) begin
                errors++;
                $display("FAIL run_tap k=%0d tap=%0d: got %h expected %h", k, tap, act, exp_v);
            end
            if (wr_busy && k == 0) begin
                wr_en = 1'b1; wr_sel = 1'b0; wr_addr = AW'(2); wr_data = 8'hAA;
            end else begin
                wr_en = 1'b0;
            end
            step();
        end
        wr_en = 1'b0;

        act   = {busy, mode_out, pe_in, pe_filter, res_valid};
        exp_v = {1'b1, 2'd0, 8'h00, 8'h00, 1'b0};
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL capt_state tap=%0d: got %h expected %h", tap, act, exp_v);
        end
        if (use_ovr) begin
            ovr_en  = 1'b1;
            ovr_val = ovr;
        end
        step();
        ovr_en = 1'b0;

        for (int h = 0; h <= hold; h++) begin
            checks++;
            if ({busy, res_valid, mode_out, res_data} !== {1'b1, 1'b1, 2'd0, exp_res}) begin
                errors++;
                $display("FAIL out_result h=%0d: busy=%b valid=%b mode=%0d data=%h expected data=%h",
                         h, busy, res_valid, mode_out, res_data, exp_res);
            end
            if (h < hold) step();
        end

        // start coincident with the handshake must be ignored
        res_ready = 1'b1;
        start     = 1'b1;
        tap_cnt   = AW'(3);
        step();
        res_ready = 1'b0;
        start     = 1'b0;
        checks++;
        if ({busy, res_valid, mode_out} !== {1'b0, 1'b0, 2'd0}) begin
            errors++;
            $display("FAIL handshake_idle: busy=%b valid=%b mode=%0d expected 0 0 0",
                     busy, res_valid, mode_out);
        end
    endtask

    task automatic test_reset();
        clear_model();
        #3;
        checks++;
        if ({busy, res_valid, mode_out, pe_in, pe_filter, res_data} !== 29'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0",
                     {busy, res_valid, mode_out, pe_in, pe_filter, res_data});
        end
        step();
        rst = 1'b0;
        step();
        checks++;
        if ({busy, res_valid, mode_out, res_data} !== 12'd0) begin
            errors++;
            $display("FAIL post_reset_idle: got %h expected 0", {busy, res_valid, mode_out, res_data});
        end
    endtask

    task automatic test_basic();
        for (int i = 0; i < 3; i++) begin
            do_write(1'b0, i, 8'(i + 1));
            do_write(1'b1, i, 8'(i + 4));
        end
        run_check(3, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic test_hold();
        run_check(3, 1'b0, 1'b0, 8'h00, 4);
    endtask

    task automatic test_tap_count();
        start   = 1'b1;
        tap_cnt = '0;
        step();
        start   = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({busy, mode_out} !== 3'd0) begin
                errors++;
                $display("FAIL tap_zero_ignored: busy=%b mode=%0d expected 0 0", busy, mode_out);
            end
            step();
        end
        for (int i = 3; i < DEPTH; i++) begin
            do_write(1'b0, i, 8'($urandom_range(0, 255)));
            do_write(1'b1, i, 8'($urandom_range(0, 255)));
        end
        run_check(12, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic test_dropped_writes();
        do_write(1'b0, 2, 8'h11);
        do_write(1'b1, 2, 8'h22);
        run_check(3, 1'b1, 1'b0, 8'h00, 0);
        do_write(1'b0, 10, 8'h77);
        do_write(1'b1, 15, 8'h66);
        run_check(DEPTH, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic test_random();
        for (int it = 0; it < 8; it++) begin
            for (int w = 0; w < 10; w++) begin
                do_write(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                         8'($urandom_range(0, 255)));
            end
            run_check(int'($urandom_range(1, 15)), 1'b0, 1'b0, 8'h00,
                      int'($urandom_range(0, 2)));
        end
    endtask

    task automatic test_async_reset();
        start   = 1'b1;
        tap_cnt = AW'(5);
        step();
        start   = 1'b0;
        step();
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if ({busy, mode_out, pe_in, pe_filter, res_valid} !== 20'd0) begin
            errors++;
            $display("FAIL async_reset_midrun: got %h expected 0",
                     {busy, mode_out, pe_in, pe_filter, res_valid});
        end
        clear_model();
        step();
        rst = 1'b0;
        step();
        run_check(DEPTH, 1'b0, 1'b0, 8'h00, 0);
    endtask

    task automatic test_relu();
        for (int i = 0; i < 3; i++) begin
            do_write(1'b0, i, 8'(i + 2));
            do_write(1'b1, i, 8'(3 * i + 1));
        end
        run_check(3, 1'b0, 1'b1, 8'hF0, 0);
        run_check(3, 1'b0, 1'b1, 8'h35, 0);
        run_check(2, 1'b0, 1'b1, 8'h80, 1);
    endtask

    initial begin
        test_reset();
        test_basic();
        test_hold();
        test_tap_count();
        test_dropped_writes();
        test_random();
        test_async_reset();
        test_relu();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
